// File: rtl/bus_fifo_pkg.sv
// rtl/bus_fifo_pkg.sv - register map, status layout and helpers for bus_fifo_port
package bus_fifo_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_OCNT = 2'd2;
  localparam logic [1:0] REG_ICNT = 2'd3;

  localparam int ST_OUT_FULL  = 0;
  localparam int ST_OUT_EMPTY = 1;
  localparam int ST_IN_FULL   = 2;
  localparam int ST_IN_EMPTY  = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_UNDERRUN  = 5;
  localparam int ST_IRQ_EN    = 6;

  typedef struct packed {
    logic rsvd;
    logic irq_en;
    logic underrun;
    logic overrun;
    logic in_empty;
    logic in_full;
    logic out_empty;
    logic out_full;
  } status_t;

  // A 256-deep FIFO holds one more entry than a byte can show; saturate.
  function automatic logic [7:0] cnt_to_byte(input int unsigned c);
    return (c > 32'd255) ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with guarded push/pop and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the pre-cycle count, so a push into a full FIFO is
  // dropped even if a pop happens in the same cycle.
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign rdata   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_fifo_port.sv
// rtl/bus_fifo_port.sv - 8088 I/O port window over an outbound and an inbound FIFO
module bus_fifo_port
  import bus_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CS,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [ADDR_WIDTH-1:0] Address,
  inout  wire  [7:0]            Data,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_rd_q, r_wr_q;
  logic          r_rd_blk, r_wr_blk;
  logic          r_irq_en, r_overrun, r_underrun, r_irq;

  logic [1:0]    w_sel;
  logic          w_rd_trail, w_wr_trail;
  logic          w_out_push, w_in_pop, w_ctrl_wr;
  logic          w_out_full, w_out_empty, w_in_full, w_in_empty;
  logic [7:0]    w_in_head;
  logic [CW-1:0] w_out_count, w_in_count;
  status_t       w_status;
  logic [7:0]    w_rd_byte;
  logic          w_unused_addr;

  assign w_sel         = Address[1:0];
  assign w_unused_addr = ^Address[ADDR_WIDTH-1:2];
  assign w_rd_trail    = CS & ~r_rd_q & RD;
  assign w_wr_trail    = CS & ~r_wr_q & WR;
  assign w_out_push    = w_wr_trail & (w_sel == REG_DATA);
  assign w_in_pop      = w_rd_trail & (w_sel == REG_DATA);
  assign w_ctrl_wr     = w_wr_trail & (w_sel == REG_STAT);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_out_fifo (
    .CLK(CLK), .RESET(RESET),
    .push(w_out_push), .wdata(Data),
    .pop(rx_ready), .rdata(rx_data),
    .full(w_out_full), .empty(w_out_empty), .count(w_out_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_in_fifo (
    .CLK(CLK), .RESET(RESET),
    .push(tx_valid), .wdata(tx_data),
    .pop(w_in_pop), .rdata(w_in_head),
    .full(w_in_full), .empty(w_in_empty), .count(w_in_count)
  );

  assign rx_valid = ~w_out_empty;
  assign tx_ready = ~w_in_full;
  assign irq      = r_irq;

  always_comb begin
    w_status           = '0;
    w_status.out_full  = w_out_full;
    w_status.out_empty = w_out_empty;
    w_status.in_full   = w_in_full;
    w_status.in_empty  = w_in_empty;
    w_status.overrun   = r_overrun;
    w_status.underrun  = r_underrun;
    w_status.irq_en    = r_irq_en;
  end

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_sel)
      REG_DATA: w_rd_byte = w_in_head;
      REG_STAT: w_rd_byte = w_status;
      REG_OCNT: w_rd_byte = cnt_to_byte(32'(w_out_count));
      REG_ICNT: w_rd_byte = cnt_to_byte(32'(w_in_count));
      default:  w_rd_byte = 8'h00;
    endcase
  end

  assign Data = (CS && !RD && WR) ? w_rd_byte : 8'hzz;

  // The *_blk flags hold the strobe history at 1 after reset until the strobe
  // is seen high, so a strobe already low at reset never yields a trailing edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_q     <= 1'b1;
      r_wr_q     <= 1'b1;
      r_rd_blk   <= 1'b1;
      r_wr_blk   <= 1'b1;
      r_irq_en   <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_q   <= RD | r_rd_blk;
      r_wr_q   <= WR | r_wr_blk;
      r_rd_blk <= r_rd_blk & ~RD;
      r_wr_blk <= r_wr_blk & ~WR;
      if (w_ctrl_wr) r_irq_en <= Data[ST_IRQ_EN];
      if (w_out_push && w_out_full)
        r_overrun <= 1'b1;
      else if (w_ctrl_wr && Data[ST_OVERRUN])
        r_overrun <= 1'b0;
      if (w_in_pop && w_in_empty)
        r_underrun <= 1'b1;
      else if (w_ctrl_wr && Data[ST_UNDERRUN])
        r_underrun <= 1'b0;
      r_irq <= r_irq_en & ~w_in_empty;
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// tb/tb_bus_fifo_port.sv - directed self-checking bench for bus_fifo_port
module tb_bus_fifo_port;

  logic        CLK = 1'b0;
  logic        RESET, CS, RD, WR;
  logic [15:0] Address;
  wire  [7:0]  Data;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, irq;
  logic [7:0]  tb_dout;
  logic        tb_oe;
  logic [7:0]  rd_val;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  // Undriven bus floats high, so high-Z reads as 8'hFF.
  assign Data = tb_oe ? tb_dout : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (Data[g]);
  end

  bus_fifo_port #(.DEPTH(16), .ADDR_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .RD(RD), .WR(WR),
    .Address(Address), .Data(Data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] v);
    CS = 1'b1; Address = {14'h0, a}; tb_dout = v; tb_oe = 1'b1; WR = 1'b0;
    cyc(1);
    WR = 1'b1;
    cyc(1);
    CS = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
    CS = 1'b1; Address = {14'h0, a}; RD = 1'b0;
    #1 v = Data;
    cyc(1);
    RD = 1'b1;
    cyc(1);
    CS = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CS = 1'b0; RD = 1'b1; WR = 1'b1; Address = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0; tb_dout = '0; tb_oe = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(1);

    check("rst_irq", irq, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_data_z", Data, 8'hFF);
    cpu_read(2'd1, rd_val);
    check("rst_status", rd_val, 8'h0A);

    cpu_write(2'd0, 8'hA5);
    cpu_write(2'd0, 8'h3C);
    cpu_read(2'd2, rd_val);
    check("ocnt_2", rd_val, 8'd2);
    check("rx_valid_2", rx_valid, 1'b1);
    check("rx_head_a5", rx_data, 8'hA5);
    rx_ready = 1'b1;
    cyc(1);
    check("rx_head_3c", rx_data, 8'h3C);
    cyc(1);
    check("rx_valid_drain", rx_valid, 1'b0);
    rx_ready = 1'b0;

    for (int i = 0; i < 17; i++) cpu_write(2'd0, 8'h80 + 8'(i));
    cpu_read(2'd2, rd_val);
    check("ocnt_full", rd_val, 8'd16);
    cpu_read(2'd1, rd_val);
    check("status_overrun", rd_val, 8'h19);
    cpu_write(2'd1, 8'h10);
    cpu_read(2'd1, rd_val);
    check("status_ovr_clr", rd_val, 8'h09);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), rx_data, 8'h80 + 8'(i));
      cyc(1);
    end
    check("drain_empty", rx_valid, 1'b0);
    rx_ready = 1'b0;

    cpu_write(2'd1, 8'h40);
    cpu_read(2'd1, rd_val);
    check("status_irq_en", rd_val, 8'h4A);
    tx_data = 8'h11; tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("irq_n1", irq, 1'b0);
    cyc(1);
    check("irq_n2", irq, 1'b1);
    cpu_read(2'd3, rd_val);
    check("icnt_1", rd_val, 8'd1);
    cpu_read(2'd0, rd_val);
    check("data_11", rd_val, 8'h11);
    cyc(1);
    check("irq_fall", irq, 1'b0);

    cpu_read(2'd0, rd_val);
    check("underrun_data", rd_val, 8'h00);
    cpu_read(2'd1, rd_val);
    check("status_underrun", rd_val, 8'h6A);
    cpu_read(2'd3, rd_val);
    check("icnt_0", rd_val, 8'd0);
    cpu_write(2'd1, 8'h20);
    cpu_read(2'd1, rd_val);
    check("status_unr_clr", rd_val, 8'h0A);

    for (int i = 0; i < 5; i++) cpu_write(2'd0, 8'h50 + 8'(i));
    cpu_read(2'd2, rd_val);
    check("ocnt_5", rd_val, 8'd5);
    CS = 1'b1; Address = '0; tb_dout = 8'h77; tb_oe = 1'b1; WR = 1'b0;
    cyc(1);
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    cyc(2);
    WR = 1'b1;
    cyc(1);
    CS = 1'b0; tb_oe = 1'b0;
    #1;
    check("midrst_data_z", Data, 8'hFF);
    check("midrst_rx_valid", rx_valid, 1'b0);
    cyc(1);
    cpu_read(2'd2, rd_val);
    check("midrst_ocnt", rd_val, 8'd0);
    cpu_read(2'd1, rd_val);
    check("midrst_status", rd_val, 8'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_fifo_port.md
# bus_fifo_port

Buffered 8-bit I/O peripheral on the 8088 demultiplexed system bus, downstream of the address latch, 8286 transceiver and I/O chip-select decode. It gives the CPU a four-register port window (data, status/control, two counts) backed by two FIFOs. The outbound FIFO carries CPU writes to a back-end consumer; the inbound FIFO carries back-end bytes to CPU reads. It raises an interrupt request while inbound data is pending.

## Interface
- DEPTH, 16, entries per FIFO; power of two, 2..256
- ADDR_WIDTH, 16, width of latched bus address input; only bits [1:0] decoded
- CLK  in  1  system clock, same CLK as the 8088
- RESET  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- CS  in  1  active-high chip select from I/O decode (IOM & address match)
- RD  in  1  active-low read strobe from CPU
- WR  in  1  active-low write strobe from CPU
- Address  in  ADDR_WIDTH  latched bus address
- Data  inout  8  system data bus, transceiver side
- rx_data  out  8  head of outbound FIFO (CPU→back-end)
- rx_valid  out  1  outbound FIFO non-empty
- rx_ready  in  1  back-end pops outbound when rx_valid & rx_ready
- tx_data  in  8  byte from back-end
- tx_valid  in  1  back-end offers byte
- tx_ready  out  1  inbound FIFO not full; push when tx_valid & tx_ready
- irq  out  1  registered interrupt request, active-high

## Operation
- Register map (Address[1:0]): 0 DATA, 1 STATUS/CTRL, 2 OUT_COUNT, 3 IN_COUNT.
- Strobe edge detect: RD and WR registered each CLK. Trailing edge = previous 0, current 1, with CS high in the same cycle. All register side effects occur only on trailing edges.
- DATA write: push Data into outbound FIFO. If full, drop the byte and set sticky overrun.
- DATA read: Data driven from the inbound FIFO head while CS & ~RD. Pop on RD trailing edge. If the FIFO is empty, drive 8'h00, no pop, and set sticky underrun.
- STATUS read: bit0 out_full, bit1 out_empty, bit2 in_full, bit3 in_empty, bit4 overrun, bit5 underrun, bit6 irq_en, bit7 0.
- CTRL write: bit6 loads irq_en. Bit4=1 clears overrun; bit5=1 clears underrun (write-1-to-clear). Bits 7, 3:0 ignored.
- OUT_COUNT/IN_COUNT read: zero-extended occupancy (0..DEPTH). Writes ignored.
- Data is high-Z whenever CS is low or RD is high. It is never driven during WR low.
- Back-end side follows a valid/ready handshake.
  - rx_valid = ~out_empty; rx_data = outbound head.
  - tx_ready = ~in_full.
- irq <= irq_en & ~in_empty, registered every cycle.
- Simultaneous events:
  - CPU push and back-end pop on the outbound FIFO in the same cycle: both occur, count unchanged. If the FIFO is full, the push is still dropped (ready checked on pre-cycle state).
  - Back-end push and CPU pop on the inbound FIFO in the same cycle: both occur.
  - Clear and set of a sticky flag in the same cycle: set wins.
- Pointers wrap modulo DEPTH. Count is a separate $clog2(DEPTH)+1-bit counter.

## Timing
- Reset values:
  - FIFOs empty, counts 0, pointers 0.
  - irq_en 0, overrun 0, underrun 0.
  - irq 0, rx_valid 0, tx_ready 1, rx_data 8'h00.
  - Data high-Z.
- RESET mid-bus-cycle: all state cleared, strobe history registers set to 1 (deasserted). The in-progress strobe's trailing edge then produces no action.
- CPU write: trailing edge in cycle N. FIFO updated at end of N; rx_valid/OUT_COUNT reflect it in N+1.
- Back-end push in cycle N: in_empty falls in N+1, irq rises in N+2 (if irq_en).
- Read data: combinational from head to Data. Stable for the whole RD-low window because the pop happens only after RD rises.
- No wait states; READY is not driven by this block.

## Structure
- Package bus_fifo_pkg holds:
  - register offset localparams (REG_DATA=0, REG_STAT=1, REG_OCNT=2, REG_ICNT=3);
  - status bit index constants;
  - a status_t packed struct.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports CLK, RESET, push, wdata, pop, rdata, full, empty, count). Instantiated twice.
- Top holds the strobe edge detect, register decode, tri-state driver and irq register.

## Test plan
- Reset, then read STATUS: expect 8'h0A (both empty). irq=0, tx_ready=1.
- CPU writes 8'hA5, 8'h3C to DATA; rx_ready=0; read OUT_COUNT: expect 2. Then set rx_ready=1: rx_data A5 then 3C over two cycles, rx_valid falls after.
- Write 17 bytes with DEPTH=16, rx_ready=0: OUT_COUNT=16, STATUS bit4=1. Write CTRL 8'h10: bit4 clears.
- Write CTRL 8'h40; back-end pushes 8'h11: irq rises 2 cycles later. CPU reads DATA → 8'h11; irq falls after the pop.
- Read DATA with inbound empty: Data=8'h00, STATUS bit5=1, IN_COUNT stays 0.
- Assert RESET while WR low with outbound count 5: count 0, no push on the following WR rise, Data high-Z.
